sound_ctrl: RTL and testbench

Note sequencer that drives the square-wave tone generator. It accepts queued note commands (divisor + duration) over a valid/ready handshake, times each note on a millisecond tick derived from the 50 MHz clock, and presents divisor/enable to the tone generator. It sits between the CPU-side sound register logic and the tone divider, so the CPU never has to time notes itself.

---
 rtl/sound_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sound_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sound_ctrl.sv
// sound_ctrl: queued note sequencer that times divisor/enable for the square-wave tone generator.
// Build option SOUND_CTRL_GAP_EN inserts one silent duration tick after every played note.
//
// state | meaning
// IDLE  | nothing playing; loads the FIFO head as soon as one is queued
// PLAY  | note loaded, prescaler and duration counter running
// GAP   | silent tick between notes, divisor held (only with SOUND_CTRL_GAP_EN)
module sound_ctrl #(
    parameter int TICK_DIV = 50000,
    parameter int DEPTH    = 4,
    parameter int DIV_W    = 15,
    parameter int DUR_W    = 8
) (
    input  logic             CLK_50MHZ,
    input  logic             RESET,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [DIV_W-1:0] REQ_DIV,
    input  logic [DUR_W-1:0] REQ_DUR,
    input  logic             ABORT,
    output logic [DIV_W-1:0] TONE_DIV,
    output logic             TONE_ON,
    output logic             BUSY,
    output logic             DONE
);

`ifdef SOUND_CTRL_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PRE_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t             state, state_nx;
    logic [DIV_W-1:0]   mem_div [DEPTH];
    logic [DUR_W-1:0]   mem_dur [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count, count_nx;
    logic               not_full_q;
    logic [PRE_W-1:0]   presc;
    logic [DUR_W-1:0]   dur_cnt;
    logic [DIV_W-1:0]   tone_div;
    logic               tone_on;
    logic               done_q;

    logic               push, fifo_empty, wrap, note_end;
    logic               load, stop, enter_gap, done_nx;
    logic [DIV_W-1:0]   head_div;
    logic [DUR_W-1:0]   head_dur;

    assign REQ_READY  = not_full_q && !ABORT && !RESET;
    assign push       = REQ_VALID && REQ_READY;
    assign fifo_empty = (count == '0);
    assign head_div   = mem_div[rd_ptr];
    assign head_dur   = mem_dur[rd_ptr];
    assign wrap       = (presc == PRE_W'(TICK_DIV - 1));
    // dur_cnt of zero only happens for a discarded (dur=0) note, which ends one cycle after load
    assign note_end   = (state == PLAY) && ((dur_cnt == '0) || (wrap && dur_cnt == DUR_W'(1)));
    assign count_nx   = count + CNT_W'(push) - CNT_W'(load);

    assign TONE_DIV = tone_div;
    assign TONE_ON  = tone_on;
    assign DONE     = done_q;
    assign BUSY     = (state != IDLE) || !fifo_empty;

    always_ff @(posedge CLK_50MHZ) begin
        if (RESET || ABORT)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        stop      = 1'b0;
        enter_gap = 1'b0;
        done_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    load     = 1'b1;
                    state_nx = PLAY;
                end
            end
            PLAY: begin
                if (note_end) begin
                    done_nx = 1'b1;
                    if (GAP_EN && dur_cnt != '0) begin
                        enter_gap = 1'b1;
                        state_nx  = GAP;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        stop     = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            GAP: begin
                if (wrap) begin
                    if (!fifo_empty) begin
                        load     = 1'b1;
                        state_nx = PLAY;
                    end else begin
                        stop     = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        if (ABORT) begin
            state_nx  = IDLE;
            load      = 1'b0;
            stop      = 1'b0;
            enter_gap = 1'b0;
            done_nx   = 1'b0;
        end
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (push) begin
            mem_div[wr_ptr] <= REQ_DIV;
            mem_dur[wr_ptr] <= REQ_DUR;
        end
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (RESET || ABORT) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            not_full_q <= !RESET;
            presc      <= '0;
            dur_cnt    <= '0;
            tone_div   <= '0;
            tone_on    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (load)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count      <= count_nx;
            not_full_q <= (count_nx != CNT_W'(DEPTH));
            done_q     <= done_nx;
            if (load) begin
                tone_div <= head_div;
                tone_on  <= (head_div != '0) && (head_dur != '0);
                dur_cnt  <= head_dur;
                presc    <= '0;
            end else if (enter_gap) begin
                tone_on <= 1'b0;
                presc   <= '0;
            end else if (stop) begin
                tone_on  <= 1'b0;
                tone_div <= '0;
                dur_cnt  <= '0;
                presc    <= '0;
            end else if (state != IDLE) begin
                presc <= wrap ? '0 : presc + PRE_W'(1);
                if (wrap && state == PLAY)
                    dur_cnt <= dur_cnt - DUR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sound_ctrl.sv
// Bench for sound_ctrl: directed note sequences then random traffic, checked against a
// note-schedule model (load/end times computed arithmetically) and a DONE scoreboard.
module tb_sound_ctrl;
    localparam int TICK_DIV = 10;
    localparam int DEPTH    = 4;
    localparam int DIV_W    = 15;
    localparam int DUR_W    = 8;

    logic             CLK_50MHZ = 1'b0;
    logic             RESET, REQ_VALID, ABORT;
    logic [DIV_W-1:0] REQ_DIV;
    logic [DUR_W-1:0] REQ_DUR;
    logic             REQ_READY, TONE_ON, BUSY, DONE;
    logic [DIV_W-1:0] TONE_DIV;

    sound_ctrl #(.TICK_DIV(TICK_DIV), .DEPTH(DEPTH), .DIV_W(DIV_W), .DUR_W(DUR_W)) dut (
        .CLK_50MHZ(CLK_50MHZ), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_DIV(REQ_DIV), .REQ_DUR(REQ_DUR), .ABORT(ABORT), .TONE_DIV(TONE_DIV),
        .TONE_ON(TONE_ON), .BUSY(BUSY), .DONE(DONE)
    );

    always #10 CLK_50MHZ = ~CLK_50MHZ;

    // a: accept edge, l: load edge, d: ending edge (DONE follows), e: edge the note stops occupying the player
    typedef struct {
        int a, l, d, e, on_end;
        bit tone;
        logic [DIV_W-1:0] div;
    } note_t;

    note_t notes[$];
    int    sb_done[$];
    int    cyc = 0;
    int    last_e = 0;
    int    last_done_seen = -1;
    bit    run = 1'b0;
    int    vectors = 0;
    int    miscompares = 0;

    always @(posedge CLK_50MHZ) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int queued_at(input int t);
        int n = 0;
        foreach (notes[i])
            if (notes[i].a <= t && t < notes[i].l) n++;
        return n;
    endfunction

    // Drive inputs for the next edge and advance the model to it.
    task automatic step(input bit v, input int dv, input int du, input bit ab, output bit acc);
        int x;
        note_t n;
        x = cyc + 1;
        REQ_VALID = v;
        REQ_DIV   = DIV_W'(dv);
        REQ_DUR   = DUR_W'(du);
        ABORT     = ab;
        if (ab) begin
            foreach (notes[i]) begin
                if (notes[i].l > x)      notes[i].l = x;
                if (notes[i].on_end > x) notes[i].on_end = x;
                if (notes[i].e > x)      notes[i].e = x;
            end
            while (sb_done.size() > 0 && sb_done[$] >= x) void'(sb_done.pop_back());
            if (last_e > x) last_e = x;
        end
        acc = v && !ab && (queued_at(cyc) < DEPTH);
        if (acc) begin
            n.a    = x;
            n.l    = (x + 1 > last_e) ? x + 1 : last_e;
            n.div  = DIV_W'(dv);
            n.tone = (dv != 0) && (du != 0);
            if (du == 0) begin
                n.d = n.l + 1;
                n.e = n.d;
            end else begin
                n.d = n.l + du * TICK_DIV;
`ifdef SOUND_CTRL_GAP_EN
                n.e = n.d + TICK_DIV;
`else
                n.e = n.d;
`endif
            end
            n.on_end = n.d;
            last_e   = n.e;
            notes.push_back(n);
            sb_done.push_back(n.d);
        end
        while (notes.size() > 0 && notes[0].e + 2 < cyc) notes.delete(0);
        @(posedge CLK_50MHZ);
        #1;
    endtask

    task automatic push_note(input int dv, input int du);
        bit acc;
        int n = 0;
        do begin
            step(1'b1, dv, du, 1'b0, acc);
            n++;
        end while (!acc && n < 500);
        if (!acc) check("push_timeout", n, 0);
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) step(1'b0, 0, 0, 1'b0, acc);
    endtask

    // Monitor: compares every cycle against the schedule, pops the DONE scoreboard on each pulse.
    always @(negedge CLK_50MHZ) begin : mon
        int t, cnt;
        logic exp_on, exp_busy;
        logic [DIV_W-1:0] exp_div;
        if (!run && cyc > 0) begin
            check("rst_ready", REQ_READY, 0);
            check("rst_tone_on", TONE_ON, 0);
            check("rst_tone_div", TONE_DIV, 0);
            check("rst_busy", BUSY, 0);
            check("rst_done", DONE, 0);
        end else if (run) begin
            t = cyc;
            cnt = 0; exp_on = 1'b0; exp_busy = 1'b0; exp_div = '0;
            foreach (notes[i]) begin
                if (notes[i].a <= t && t < notes[i].e) exp_busy = 1'b1;
                if (notes[i].l <= t && t < notes[i].e) exp_div = notes[i].div;
                if (notes[i].tone && notes[i].l <= t && t < notes[i].on_end) exp_on = 1'b1;
                if (notes[i].a <= t && t < notes[i].l) cnt++;
            end
            check("tone_on", TONE_ON, exp_on);
            check("tone_div", TONE_DIV, exp_div);
            check("busy", BUSY, exp_busy);
            check("req_ready", REQ_READY, (cnt < DEPTH) && !ABORT);
            while (sb_done.size() > 0 && sb_done[0] < t)
                check("done_missing", last_done_seen, sb_done.pop_front());
            if (DONE === 1'b1) begin
                if (sb_done.size() == 0)
                    check("done_unexpected", t, -1);
                else
                    check("done_time", t, sb_done.pop_front());
                last_done_seen = t;
            end
        end
    end

    initial begin
        bit acc;
        RESET = 1'b1; REQ_VALID = 1'b0; ABORT = 1'b0; REQ_DIV = '0; REQ_DUR = '0;
        repeat (3) begin @(posedge CLK_50MHZ); #1; end
        RESET = 1'b0;
        @(posedge CLK_50MHZ); #1;
        run = 1'b1;

        push_note(100, 3);
        idle(40);

        for (int i = 1; i <= 5; i++) push_note(10 * i, 1);
        idle(60);

        push_note(0, 2);
        push_note(7, 0);
        idle(30);

        push_note(100, 5);
        push_note(200, 5);
        idle(13);
        step(1'b1, 300, 2, 1'b1, acc);
        idle(20);

        push_note(100, 2);
        push_note(200, 2);
        idle(70);

        for (int i = 0; i < 2500; i++)
            step($urandom_range(0, 3) == 0,
                 ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 32767)),
                 int'($urandom_range(0, 3)),
                 $urandom_range(0, 79) == 0, acc);

        idle(250);
        check("sb_drained", sb_done.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
